dmem_ctrl: RTL and testbench

- Data-side memory block that sits directly downstream of the core's data interface (adr_v/adr/is_store/store_data/load_data/access_size).
- Contains a word-organised data RAM with byte-lane write masking and combinational read with right-alignment.
- Also has a small MMIO window: a tohost register for ending simulation, and a free-running cycle counter.
- Flags misaligned and out-of-range accesses with sticky error flags.

---
 rtl/dmem_ctrl.sv | 178 +++++++++++++++++
 tb/tb_dmem_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// Data-side memory block behind the core's data port.
// It contains a word-organised RAM with byte-lane store masking and a
// combinational, right-aligned load path. It also has an MMIO window that
// holds the tohost register and a free-running cycle counter, plus sticky
// misalignment and range error flags.
// The byte-lane logic is written for XLEN = 32 (four byte lanes).
module dmem_ctrl #(
    parameter int              XLEN        = 32,
    parameter int              DEPTH_WORDS = 1024,
    parameter logic [XLEN-1:0] RAM_BASE    = 32'h0000_0000,
    parameter logic [XLEN-1:0] TOHOST_ADR  = 32'h1000_0000,
    parameter logic [XLEN-1:0] CYCLE_ADR   = 32'h1000_0008
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            adr_v_i,
    input  logic [XLEN-1:0] adr_i,
    input  logic            is_store_i,
    input  logic [XLEN-1:0] store_data_i,
    input  logic [2:0]      access_size_i,
    output logic [XLEN-1:0] load_data_o,
    output logic            tohost_v_o,
    output logic [XLEN-1:0] tohost_data_o,
    output logic            misalign_err_o,
    output logic            range_err_o,
    output logic [XLEN-1:0] err_adr_o
);

    localparam int            AW       = $clog2(DEPTH_WORDS);
    // The end of the window is computed one bit wider, so that a window at
    // the top of the address space does not wrap.
    localparam logic [XLEN:0] RAM_SPAN = (XLEN+1)'(DEPTH_WORDS) << 2;
    localparam logic [XLEN:0] RAM_END  = {1'b0, RAM_BASE} + RAM_SPAN;

    logic [XLEN-1:0] r_mem [DEPTH_WORDS];
    logic            r_tohost_v;
    logic [XLEN-1:0] r_tohost_data;
    logic            r_misalign;
    logic            r_range;
    logic [XLEN-1:0] r_err_adr;
    logic [XLEN-1:0] r_cycle;

    logic            w_size_ok;
    logic            w_align_ok;
    logic            w_legal;
    logic            w_mis_err;
    logic            w_rng_err;
    logic            w_ram_hit;
    logic            w_toh_hit;
    logic            w_cyc_hit;
    logic [AW-1:0]   w_idx;
    logic [XLEN-1:0] w_word;
    logic [1:0]      w_lane;
    logic [4:0]      w_shamt;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_wdata_rep;
    logic [XLEN-1:0] w_merged;
    logic [XLEN-1:0] w_mask;
    logic [XLEN-1:0] w_shifted;
    logic            w_st;
    logic            w_ram_we;
    logic            w_toh_we;
    logic            w_cyc_we;

    assign w_lane  = adr_i[1:0];
    assign w_shamt = {w_lane, 3'b000};

    // Size legality, alignment, byte enables, lane replication and load mask.
    always_comb begin
        w_size_ok   = 1'b0;
        w_align_ok  = 1'b0;
        w_be        = 4'b0000;
        w_wdata_rep = store_data_i;
        w_mask      = '0;
        case (access_size_i)
            3'b001: begin
                w_size_ok   = 1'b1;
                w_align_ok  = 1'b1;
                w_be        = 4'b0001 << w_lane;
                w_wdata_rep = {4{store_data_i[7:0]}};
                w_mask      = 32'h0000_00FF;
            end
            3'b010: begin
                w_size_ok   = 1'b1;
                w_align_ok  = ~adr_i[0];
                w_be        = adr_i[1] ? 4'b1100 : 4'b0011;
                w_wdata_rep = {2{store_data_i[15:0]}};
                w_mask      = 32'h0000_FFFF;
            end
            3'b100: begin
                w_size_ok   = 1'b1;
                w_align_ok  = (adr_i[1:0] == 2'b00);
                w_be        = 4'b1111;
                w_wdata_rep = store_data_i;
                w_mask      = 32'hFFFF_FFFF;
            end
            default: begin
                w_size_ok   = 1'b0;
                w_align_ok  = 1'b0;
            end
        endcase
    end

    assign w_legal   = adr_v_i & w_size_ok & w_align_ok;
    assign w_mis_err = adr_v_i & ~(w_size_ok & w_align_ok);

    assign w_ram_hit = ({1'b0, adr_i} >= {1'b0, RAM_BASE}) && ({1'b0, adr_i} < RAM_END);
    assign w_toh_hit = (adr_i[XLEN-1:2] == TOHOST_ADR[XLEN-1:2]);
    assign w_cyc_hit = (adr_i[XLEN-1:2] == CYCLE_ADR[XLEN-1:2]);
    assign w_idx     = AW'((adr_i - RAM_BASE) >> 2);
    assign w_rng_err = w_legal & ~(w_ram_hit | w_toh_hit | w_cyc_hit);

    // Select the addressed word. An unmapped address reads as zero.
    always_comb begin
        w_word = '0;
        if (w_ram_hit) begin
            w_word = r_mem[w_idx];
        end else if (w_toh_hit) begin
            w_word = r_tohost_data;
        end else if (w_cyc_hit) begin
            w_word = r_cycle;
        end
    end

    // Per-lane merge of store data over the current word content.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign w_merged[gi*8 +: 8] = w_be[gi] ? w_wdata_rep[gi*8 +: 8] : w_word[gi*8 +: 8];
    end

    assign w_st     = w_legal & is_store_i;
    assign w_ram_we = w_st & w_ram_hit;
    assign w_toh_we = w_st & ~w_ram_hit & w_toh_hit;
    assign w_cyc_we = w_st & ~w_ram_hit & ~w_toh_hit & w_cyc_hit;

    assign w_shifted   = w_word >> w_shamt;
    assign load_data_o = (w_legal & ~is_store_i) ? (w_shifted & w_mask) : '0;

    // RAM store. It is not reset, and a store during reset is discarded.
    always_ff @(posedge clk) begin
        if (reset_n && w_ram_we) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    // MMIO registers, sticky error flags, and first-error address capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tohost_v    <= 1'b0;
            r_tohost_data <= '0;
            r_misalign    <= 1'b0;
            r_range       <= 1'b0;
            r_err_adr     <= '0;
            r_cycle       <= '0;
        end else begin
            if (w_toh_we) begin
                r_tohost_v    <= 1'b1;
                r_tohost_data <= w_merged;
            end
            r_cycle <= w_cyc_we ? w_merged : r_cycle + 1'b1;
            if (w_mis_err) begin
                r_misalign <= 1'b1;
            end
            if (w_rng_err) begin
                r_range <= 1'b1;
            end
            if (!(r_misalign | r_range) && (w_mis_err | w_rng_err)) begin
                r_err_adr <= adr_i;
            end
        end
    end

    assign tohost_v_o     = r_tohost_v;
    assign tohost_data_o  = r_tohost_data;
    assign misalign_err_o = r_misalign;
    assign range_err_o    = r_range;
    assign err_adr_o      = r_err_adr;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl. The stimulus pushes expected values, each
// tagged with the cycle in which it must hold. The monitor compares them on
// the falling edge.
module tb_dmem_ctrl;

    localparam logic [31:0] TOHOST = 32'h1000_0000;
    localparam logic [31:0] CYCLE  = 32'h1000_0008;
    localparam int K_LOAD = 0, K_MIS = 1, K_RNG = 2, K_ERRA = 3, K_TV = 4, K_TD = 5;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        adr_v_i = 1'b0;
    logic [31:0] adr_i = '0;
    logic        is_store_i = 1'b0;
    logic [31:0] store_data_i = '0;
    logic [2:0]  access_size_i = 3'b100;
    logic [31:0] load_data_o;
    logic        tohost_v_o;
    logic [31:0] tohost_data_o;
    logic        misalign_err_o;
    logic        range_err_o;
    logic [31:0] err_adr_o;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] exp;
        string       nm;
    } exp_t;

    exp_t q[$];
    int   cur_cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    dmem_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .adr_v_i        (adr_v_i),
        .adr_i          (adr_i),
        .is_store_i     (is_store_i),
        .store_data_i   (store_data_i),
        .access_size_i  (access_size_i),
        .load_data_o    (load_data_o),
        .tohost_v_o     (tohost_v_o),
        .tohost_data_o  (tohost_data_o),
        .misalign_err_o (misalign_err_o),
        .range_err_o    (range_err_o),
        .err_adr_o      (err_adr_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cur_cyc <= cur_cyc + 1;

    function automatic logic [31:0] observe(input int kind);
        case (kind)
            K_LOAD:  return load_data_o;
            K_MIS:   return {31'd0, misalign_err_o};
            K_RNG:   return {31'd0, range_err_o};
            K_ERRA:  return err_adr_o;
            K_TV:    return {31'd0, tohost_v_o};
            default: return tohost_data_o;
        endcase
    endfunction

    // Monitor: compare every expectation that is due in this cycle.
    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc == cur_cyc) begin
                logic [31:0] got;
                got = observe(q[i].kind);
                n_vec++;
                if (got !== q[i].exp) begin
                    n_err++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)",
                             q[i].nm, got, q[i].exp, cur_cyc);
                end else begin
                    $display("ok   %s: 0x%08h (cycle %0d)", q[i].nm, got, cur_cyc);
                end
                q.delete(i);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic acc(input logic st, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] sz);
        adr_v_i       = 1'b1;
        is_store_i    = st;
        adr_i         = a;
        store_data_i  = d;
        access_size_i = sz;
    endtask

    task automatic idle();
        adr_v_i    = 1'b0;
        is_store_i = 1'b0;
    endtask

    task automatic expect_at(input int dcyc, input int kind, input logic [31:0] v,
                             input string nm);
        exp_t e;
        e.cyc  = cur_cyc + dcyc;
        e.kind = kind;
        e.exp  = v;
        e.nm   = nm;
        q.push_back(e);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // State just after reset.
        step(); idle();
        expect_at(0, K_MIS,  0, "reset_misalign");
        expect_at(0, K_RNG,  0, "reset_range");
        expect_at(0, K_ERRA, 0, "reset_err_adr");
        expect_at(0, K_TV,   0, "reset_tohost_v");
        expect_at(0, K_TD,   0, "reset_tohost_data");
        expect_at(0, K_LOAD, 0, "idle_load_zero");

        // Word/byte merge.
        step(); acc(1, 32'h10, 32'hDEAD_BEEF, 3'b100);
        expect_at(0, K_LOAD, 0, "store_load_zero");
        step(); acc(1, 32'h12, 32'h0000_0055, 3'b001);
        step(); acc(0, 32'h10, 0, 3'b100);
        expect_at(0, K_LOAD, 32'hDE55_BEEF, "merge_word");
        step(); acc(0, 32'h13, 0, 3'b001);
        expect_at(0, K_LOAD, 32'h0000_00DE, "merge_byte3");

        // Half lanes.
        step(); acc(1, 32'h20, 32'h1122_3344, 3'b100);
        step(); acc(1, 32'h22, 32'hFFFF_A5A5, 3'b010);
        step(); acc(0, 32'h20, 0, 3'b100);
        expect_at(0, K_LOAD, 32'hA5A5_3344, "half_word");
        step(); acc(0, 32'h22, 0, 3'b010);
        expect_at(0, K_LOAD, 32'h0000_A5A5, "half_hi");
        step(); acc(0, 32'h20, 0, 3'b010);
        expect_at(0, K_LOAD, 32'h0000_3344, "half_lo");
        step(); acc(0, 32'h21, 0, 3'b001);
        expect_at(0, K_LOAD, 32'h0000_0033, "byte1");

        // Known words for later checks.
        step(); acc(1, 32'h8, 32'hCAFE_F00D, 3'b100);
        step(); acc(1, 32'h0, 32'h0BAD_C0DE, 3'b100);

        // Misaligned word load.
        step(); acc(0, 32'h6, 0, 3'b100);
        expect_at(0, K_LOAD, 0, "misalign_load_zero");
        expect_at(0, K_MIS,  0, "misalign_before_edge");
        expect_at(1, K_MIS,  1, "misalign_set");
        expect_at(1, K_ERRA, 32'h6, "err_adr_first");
        expect_at(1, K_RNG,  0, "range_still_clear");
        step(); acc(1, 32'h9, 32'h0000_FFFF, 3'b010);
        expect_at(1, K_ERRA, 32'h6, "err_adr_held");
        step(); acc(0, 32'h8, 0, 3'b100);
        expect_at(0, K_LOAD, 32'hCAFE_F00D, "misalign_store_dropped");
        step(); acc(0, 32'h10, 0, 3'b011);
        expect_at(0, K_LOAD, 0, "illegal_size_zero");

        // Range error.
        step(); acc(1, 32'h1000, 32'h1234_5678, 3'b100);
        expect_at(1, K_RNG,  1, "range_set");
        expect_at(1, K_ERRA, 32'h6, "err_adr_after_range");
        step(); acc(0, 32'h0, 0, 3'b100);
        expect_at(0, K_LOAD, 32'h0BAD_C0DE, "range_store_dropped");
        step(); acc(0, 32'h0FFC, 0, 3'b100);
        step(); acc(0, 32'h2000_0000, 0, 3'b100);
        expect_at(0, K_LOAD, 0, "unmapped_load_zero");

        // tohost.
        step(); acc(1, TOHOST, 32'h1, 3'b100);
        expect_at(1, K_TV, 1, "tohost_v");
        expect_at(1, K_TD, 32'h1, "tohost_data");
        step(); acc(1, TOHOST + 32'h2, 32'h0000_00AB, 3'b001);
        expect_at(1, K_TD, 32'h00AB_0001, "tohost_byte_merge");
        step(); acc(0, TOHOST + 32'h2, 0, 3'b010);
        expect_at(0, K_LOAD, 32'h0000_00AB, "tohost_load_half");

        // Cycle counter: load, wrap, and byte store merged with live value.
        step(); acc(1, CYCLE, 32'hFFFF_FFFE, 3'b100);
        step(); acc(0, CYCLE, 0, 3'b100);
        expect_at(0, K_LOAD, 32'hFFFF_FFFE, "cycle_loaded");
        step(); acc(0, CYCLE, 0, 3'b100);
        expect_at(0, K_LOAD, 32'hFFFF_FFFF, "cycle_inc");
        step(); acc(0, CYCLE, 0, 3'b100);
        expect_at(0, K_LOAD, 32'h0, "cycle_wrap");
        step(); acc(1, CYCLE + 32'h1, 32'h0000_007F, 3'b001);
        step(); acc(0, CYCLE, 0, 3'b100);
        expect_at(0, K_LOAD, 32'h0000_7F01, "cycle_byte_merge");

        // Asynchronous reset in the middle of a cycle, with no clock edge.
        step(); acc(0, CYCLE, 0, 3'b100);
        #2 reset_n = 1'b0;
        expect_at(0, K_MIS,  0, "async_misalign");
        expect_at(0, K_RNG,  0, "async_range");
        expect_at(0, K_ERRA, 0, "async_err_adr");
        expect_at(0, K_TV,   0, "async_tohost_v");
        expect_at(0, K_TD,   0, "async_tohost_data");
        expect_at(0, K_LOAD, 0, "async_cycle_zero");
        step(); idle();
        reset_n = 1'b1;

        repeat (3) step();
        if (q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_drain: %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Backstop so that the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation ran past limit, expected completion");
        $fatal(1, "timeout");
    end

endmodule
